// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit, one bit per cycle.
//
// A shift-add multiplier and a restoring divider share one pair of working
// registers. Both work on operand magnitudes, and the sign is applied once
// at the end. Divide-by-zero and signed overflow skip the iteration and
// finish in one cycle.
//
// Parameters:
//   XLEN   operand/result width (any even value >= 8)
//   CNT_W  iteration counter width
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operation handshake (op, rs1, rs2)
//   op                   RV32M funct3
//   rs1, rs2             operand A (multiplicand/dividend), B (multiplier/divisor)
//   flush                abort in-flight operation, discard result
//   out_valid/out_ready  result handshake
//   result               registered result, stable while out_valid
module alu_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_reg;
  logic [XLEN-1:0]   opnd_reg;    // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0]   hi_reg;      // product high half (mul) / partial remainder (div)
  logic [XLEN-1:0]   lo_reg;      // multiplier shifting out (mul) / dividend->quotient (div)
  logic              neg_reg;     // negate product or quotient
  logic              neg_rem_reg; // negate remainder (dividend was negative)
  logic [CNT_W-1:0]  count_reg;
  logic [XLEN-1:0]   result_reg;

  assign in_ready  = (state == IDLE) && !rst && !flush;
  assign out_valid = (state == DONE);
  assign result    = result_reg;

  // ---------------- operand decode (used on acceptance) ----------------
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_result;

  always_comb begin
    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM; rs2 for MUL, MULH, DIV, REM
    a_signed = op[2] ? !op[0] : (op[1:0] != 2'b11);
    b_signed = op[2] ? !op[0] : !op[1];
    a_neg    = a_signed && rs1[XLEN-1];
    b_neg    = b_signed && rs2[XLEN-1];
    mag_a    = a_neg ? (~rs1 + 1'b1) : rs1;
    mag_b    = b_neg ? (~rs2 + 1'b1) : rs2;
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = op[2] && !op[0] && (rs1 == MIN_NEG) && (rs2 == ALL_ONES);
    special_result = '0;
    if (div_zero)
      special_result = op[1] ? rs1 : ALL_ONES;
    else if (div_ovf)
      special_result = op[1] ? '0 : MIN_NEG;
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    // shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole {carry, hi, lo} right by one
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    // restoring division: bring in the next dividend bit; the partial
    // remainder is below the divisor, so the shifted value fits in XLEN+1 bits
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_reg};
    // difference is below the divisor, so the low XLEN bits are exact
    div_sub   = div_shift[XLEN-1:0] - opnd_reg;
    if (op_reg[2]) begin
      step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
      step_lo = {lo_reg[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // ---------------- final sign fix-up and select ----------------
  logic [2*XLEN-1:0] product, product_s;
  logic [XLEN-1:0]   quot_s, rem_s;
  logic [XLEN-1:0]   final_result;

  always_comb begin
    product   = {step_hi, step_lo};
    product_s = neg_reg ? (~product + 1'b1) : product;
    quot_s    = neg_reg ? (~step_lo + 1'b1) : step_lo;
    rem_s     = neg_rem_reg ? (~step_hi + 1'b1) : step_hi;
    case (op_reg)
      3'b000:                 final_result = product_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = product_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_result = quot_s;
      default:                final_result = rem_s;
    endcase
  end

  // ---------------- control and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_reg      <= '0;
      opnd_reg    <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      neg_reg     <= 1'b0;
      neg_rem_reg <= 1'b0;
      count_reg   <= '0;
      result_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_reg      <= op;
            opnd_reg    <= op[2] ? mag_b : mag_a;
            lo_reg      <= op[2] ? mag_a : mag_b;
            hi_reg      <= '0;
            neg_reg     <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
            count_reg   <= CNT_W'(XLEN);
            if (div_zero || div_ovf) begin
              result_reg <= special_result;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi_reg    <= step_hi;
            lo_reg    <= step_lo;
            count_reg <= count_reg - 1'b1;
            if (count_reg == CNT_W'(1)) begin
              result_reg <= final_result;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (flush || out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vector table, hand-written corner sequences
// (back-pressure, flush, reset mid-operation) and random operations compared
// against a 64-bit arithmetic reference model.
module tb_alu_muldiv;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     ua = longint'({32'b0, a});
    longint     ub = longint'({32'b0, b});
    logic [63:0] p;
    case (o)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = 64'(ua / ub); return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LAT;
  endfunction

  // Issue one operation, measure latency, check result, then consume it.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int k;
    bit busy_ok;
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (in_ready) busy_ok = 1'b0;
    end while (!out_valid && k < 100);
    check("latency", k, lat);
    check("busy_in_ready_low", busy_ok, 1);
    check("result", result, exp);
    $display("[TB] op=%0d rs1=%h rs2=%h result=%h expected=%h latency=%0d", o, a, b,
             result, exp, k);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        LAT};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         LAT};
    vecs[8]  = '{3'd5, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT};
    vecs[13] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         LAT};

    rst = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 check("post_reset_in_ready", in_ready, 1);

    // directed vectors
    for (int i = 0; i < 14; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // back-pressure: result held, in_ready low, in_valid ignored
    begin
      int k;
      bit stable_ok;
      @(negedge clk);
      in_valid = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
      @(posedge clk);
      #1 op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;  // keep in_valid high with another op
      k = 0;
      do begin @(negedge clk); k++; end while (!out_valid && k < 100);
      check("bp_latency", k, LAT);
      stable_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (result !== 32'd14 || !out_valid || in_ready) stable_ok = 1'b0;
      end
      check("bp_hold_stable", stable_ok, 1);
      check("bp_result", result, 14);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1 check("bp_in_ready_after", in_ready, 1);
      check("bp_out_valid_after", out_valid, 0);
      $display("[TB] back-pressure sequence done, result=%h", result);
    end

    // flush at T+10 of a DIV
    begin
      bit quiet;
      @(negedge clk);
      in_valid = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1 check("flush_in_ready", in_ready, 1);
      check("flush_out_valid", out_valid, 0);
      quiet = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (out_valid) quiet = 1'b0;
      end
      check("flush_no_result", quiet, 1);
      $display("[TB] flush mid-DIV sequence done");
    end
    do_op(3'd0, 32'd3, 32'd4, 32'd12, LAT);

    // flush in IDLE blocks acceptance
    begin
      bit quiet;
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; op = 3'd5; rs1 = 32'd9; rs2 = 32'd0;
      #1 check("idle_flush_in_ready", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      quiet = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (out_valid || !in_ready) quiet = 1'b0;
      end
      check("idle_flush_not_accepted", quiet, 1);
      $display("[TB] flush in IDLE sequence done");
    end

    // reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 check("midrst_in_ready_after", in_ready, 1);
    $display("[TB] reset mid-CALC sequence done");
    do_op(3'd3, 32'd5, 32'd6, 32'd0, LAT);

    // random operations against the reference model
    for (int i = 0; i < 80; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      int r;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = '0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) b = 32'($urandom_range(1, 15));
      else if (r == 3) a = 32'($urandom_range(0, 20));
      do_op(o, a, b, ref_model(o, a, b), ref_latency(o, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
